serial_subt_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. Accepts two WIDTH-bit operands on a start pulse. Feeds them LSB-first, one bit per clock, through a single instance of the team's 1-bit full-subtractor cell (Full_subt), holding the running borrow in a register. Returns the WIDTH-bit difference and final borrow with a done pulse. This is the low-area subtract path for lab datapaths that reuse one subtractor cell across many bits.

---
 rtl/serial_subt_ctrl_if.sv | 37 +++
 rtl/serial_subt_ctrl.sv | 155 +++++++++++++++
 tb/tb_serial_subt_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subt_ctrl_if.sv
// Handshake/data bundle for serial_subt_ctrl.
// Optional macro SERIAL_SUBT_SIGNED_EN adds the two's-complement overflow flag ovf.
interface serial_subt_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBT_SIGNED_EN
  logic             ovf;

  modport master (
    output start, a, b, bin_init,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin_init,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin_init,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin_init,
    output busy, done, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subt_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin_init, one bit per clock, LSB first,
// through a single 1-bit full-subtractor cell with a registered running borrow.
// Optional macro SERIAL_SUBT_SIGNED_EN adds the registered overflow output ovf.

// 1-bit full-subtractor cell: d = a - b - bin, bout set when the bit underflows.
module Full_subt (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subt_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_subt_ctrl_if.slave bus
);

  // Counter must be at least one bit wide so WIDTH=1 still elaborates.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("serial_subt_ctrl: WIDTH must be in 1..32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bout;
`ifdef SERIAL_SUBT_SIGNED_EN
  logic             ovf_q, ovf_d;
`endif

  // The one shared subtractor cell always works on the current LSBs and running borrow.
  Full_subt u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_SUBT_SIGNED_EN
    ovf_d     = ovf_q;
`endif
    // New difference bit enters at the MSB side; written this way so WIDTH=1 is legal.
    res_shift             = res_q >> 1;
    res_shift[WIDTH-1]    = cell_d;

    case (state_q)
      StIdle, StFin: begin
        // FIN accepts a new start just like IDLE, giving back-to-back operation.
        if (bus.start) begin
          state_d  = StRun;
          sh_a_d   = bus.a;
          sh_b_d   = bus.b;
          borrow_d = bus.bin_init;
          cnt_d    = '0;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CntW'(1);
        res_d    = res_shift;
        if (last_bit) begin
          // Only the completed result ever reaches diff/bout.
          state_d = StFin;
          diff_d  = res_shift;
          bout_d  = cell_bout;
`ifdef SERIAL_SUBT_SIGNED_EN
          // Borrow into the MSB differs from borrow out: signed overflow.
          ovf_d   = borrow_q ^ cell_bout;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUBT_SIGNED_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUBT_SIGNED_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StFin);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUBT_SIGNED_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subt_ctrl.sv
// Bench for serial_subt_ctrl: directed vectors, a cycle-level reference model compared
// every negedge, and literal expectations. SERIAL_SUBT_SIGNED_EN enables ovf checks.
module tb_serial_subt_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_subt_ctrl_if #(.WIDTH(W)) bus ();
  serial_subt_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_subt_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_subt_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the unsigned/signed definitions: {ovf, bout, diff}.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int ud, sa, sb, sd;
    logic [W-1:0] d;
    logic bo, ov;
    ud = int'(a) - int'(b) - int'(bin);
    d  = ud[W-1:0];
    bo = (ud < 0);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    sd = sa - sb - int'(bin);
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  // Model: an accepted op completes W cycles later; outputs load at completion.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W+1:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_diff <= m_pend[W-1:0];
        m_bout <= m_pend[W];
        m_ovf  <= m_pend[W+1];
      end
      if (m_left == 0 && bus.start) begin
        m_left <= W;
        m_pend <= ref_sub(bus.a, bus.b, bus.bin_init);
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", 32'(bus.busy), 32'(m_left > 0));
      chk("model_done", 32'(bus.done), 32'(m_done));
      chk("model_diff", 32'(bus.diff), 32'(m_diff));
      chk("model_bout", 32'(bus.bout), 32'(m_bout));
`ifdef SERIAL_SUBT_SIGNED_EN
      chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin_init = bin;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic bin, input logic [W-1:0] exp_d, input logic exp_b);
    int n;
    pulse(a, b, bin);
    wait_done(n);
    chk({name, "_latency"}, 32'(n), 32'(W + 1));
    chk({name, "_diff"}, 32'(bus.diff), 32'(exp_d));
    chk({name, "_bout"}, 32'(bus.bout), 32'(exp_b));
  endtask

  initial begin
    int n;
    int done_seen;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin_init  = 1'b0;
    bus1.start    = 1'b0;
    bus1.a        = '0;
    bus1.b        = '0;
    bus1.bin_init = 1'b0;

    // Reset, then idle with start low.
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_diff", 32'(bus.diff), 32'd0);

    op("op200_55", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);
    op("op10_20", 8'd10, 8'd20, 1'b0, 8'd246, 1'b1);
    op("op0_0_b1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);

    // Second start while busy must be ignored.
    pulse(8'd100, 8'd1, 1'b0);
    @(posedge clk);
    pulse(8'd5, 8'd5, 1'b0);
    wait_done(n);
    chk("ignore_diff", 32'(bus.diff), 32'd99);
    chk("ignore_bout", 32'(bus.bout), 32'd0);

    // Start held high: a new op begins straight out of FIN.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'd3;
    bus.b     = 8'd1;
    wait_done(n);
    chk("b2b_first_diff", 32'(bus.diff), 32'd2);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_nodone", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    wait_done(n);
    chk("b2b_second_lat", 32'(n), 32'(W));
    chk("b2b_second_diff", 32'(bus.diff), 32'd2);

    // Reset mid-operation.
    pulse(8'd50, 8'd20, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    op("op7_3", 8'd7, 8'd3, 1'b0, 8'd4, 1'b0);

    // Signed-overflow vectors.
    op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SERIAL_SUBT_SIGNED_EN
    chk("op80_01_ovf", 32'(bus.ovf), 32'd1);
`endif
    op("op05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
`ifdef SERIAL_SUBT_SIGNED_EN
    chk("op05_03_ovf", 32'(bus.ovf), 32'd0);
`endif

    // WIDTH=1 instance: a single RUN edge, then FIN.
    @(posedge clk);
    #1;
    bus1.start = 1'b1;
    bus1.a     = 1'b0;
    bus1.b     = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    chk("w1_busy", 32'(bus1.busy), 32'd1);
    chk("w1_early_done", 32'(bus1.done), 32'd0);
    @(posedge clk);
    #1;
    chk("w1_done", 32'(bus1.done), 32'd1);
    chk("w1_diff", 32'(bus1.diff), 32'd1);
    chk("w1_bout", 32'(bus1.bout), 32'd1);
`ifdef SERIAL_SUBT_SIGNED_EN
    chk("w1_ovf", 32'(bus1.ovf), 32'd1);
`endif
    @(posedge clk);
    #1;
    chk("w1_done_clear", 32'(bus1.done), 32'd0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
